// File: rtl/qkv_sched_pkg.sv
// Shared types and constants for the Q/K/V projection fetch scheduler.
package qkv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    ISSUE      = 3'd2,
    WAIT_DONE  = 3'd3,
    WAIT_READY = 3'd4,
    FINISH     = 3'd5
  } state_e;

  localparam logic [2:0] OFF_Q = 3'd0;
  localparam logic [2:0] OFF_K = 3'd1;
  localparam logic [2:0] OFF_V = 3'd2;

  localparam int DEF_NUM_TILES   = 24;
  localparam int DEF_NUM_OFFSETS = 3;

  // A single-tile configuration still needs a one-bit index.
  function automatic int tile_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qkv_tile_counter.sv
// Nested tile/offset counter; saturates at the last tile of the last offset group.
module qkv_tile_counter
  import qkv_sched_pkg::*;
#(
  parameter int NUM_TILES   = DEF_NUM_TILES,
  parameter int NUM_OFFSETS = DEF_NUM_OFFSETS,
  parameter int TILE_W      = tile_width(DEF_NUM_TILES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [TILE_W-1:0] tile_idx,
  output logic [2:0]        offset,
  output logic              last_tile,
  output logic              last_offset
);

  localparam logic [TILE_W-1:0] LAST_TILE   = TILE_W'(NUM_TILES - 1);
  localparam logic [2:0]        LAST_OFFSET = 3'(NUM_OFFSETS - 1);

  logic [TILE_W-1:0] tile_r;
  logic [2:0]        offset_r;

  assign tile_idx    = tile_r;
  assign offset      = offset_r;
  assign last_tile   = (tile_r == LAST_TILE);
  assign last_offset = (offset_r == LAST_OFFSET);

  // Tile index steps within a group, rolling into the next offset group at its end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tile_r   <= '0;
      offset_r <= 3'd0;
    end else if (clear) begin
      tile_r   <= '0;
      offset_r <= 3'd0;
    end else if (advance) begin
      if (!last_tile) begin
        tile_r   <= tile_r + TILE_W'(1);
        offset_r <= offset_r;
      end else if (!last_offset) begin
        tile_r   <= '0;
        offset_r <= offset_r + 3'd1;
      end else begin
        tile_r   <= tile_r;
        offset_r <= offset_r;
      end
    end else begin
      tile_r   <= tile_r;
      offset_r <= offset_r;
    end
  end

endmodule

// File: rtl/qkv_fetch_scheduler.sv
// Sequences fetch_logic_gen over all tiles of every Q/K/V offset group,
// handshaking each tile with fetch_done and the systolic array's sa_ready.
module qkv_fetch_scheduler
  import qkv_sched_pkg::*;
#(
  parameter int NUM_TILES   = DEF_NUM_TILES,
  parameter int NUM_OFFSETS = DEF_NUM_OFFSETS,
  parameter int TILE_W      = tile_width(NUM_TILES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              fetch_done,
  input  logic              sa_ready,
  output logic              start_fetch,
  output logic              reset_addr_counter,
  output logic [2:0]        Offset_Control,
  output logic [TILE_W-1:0] tile_idx,
  output logic              tile_valid,
  output logic              busy,
  output logic              pass_done,
  output logic              err
);

  state_e state_r;
  state_e state_s;

  logic err_r;
  logic err_s;
  logic clear_s;
  logic advance_s;
  logic last_tile_s;
  logic last_offset_s;

  logic start_fetch_r;
  logic reset_addr_counter_r;
  logic tile_valid_r;
  logic busy_r;
  logic pass_done_r;

  // Abort also zeroes the counters so the next pass restarts at the Q group.
  assign clear_s   = abort || ((state_r == IDLE) && start);
  assign advance_s = !abort && (state_r == WAIT_READY) && sa_ready;

  qkv_tile_counter #(
    .NUM_TILES   (NUM_TILES),
    .NUM_OFFSETS (NUM_OFFSETS),
    .TILE_W      (TILE_W)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear_s),
    .advance     (advance_s),
    .tile_idx    (tile_idx),
    .offset      (Offset_Control),
    .last_tile   (last_tile_s),
    .last_offset (last_offset_s)
  );

  // Next-state decode; abort overrides whatever the state would otherwise do.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = CLEAR;
        else       state_s = IDLE;
      end
      CLEAR:     state_s = ISSUE;
      ISSUE:     state_s = WAIT_DONE;
      WAIT_DONE: begin
        if (fetch_done) state_s = WAIT_READY;
        else            state_s = WAIT_DONE;
      end
      WAIT_READY: begin
        if (!sa_ready)                     state_s = WAIT_READY;
        else if (last_tile_s && last_offset_s) state_s = FINISH;
        else if (last_tile_s)              state_s = CLEAR;
        else                               state_s = ISSUE;
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
    if (abort) begin
      state_s = IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // Sticky protocol error: a fetch_done the scheduler was not waiting for.
  always_comb begin
    err_s = err_r;
    if (abort) begin
      err_s = err_r;
    end else if ((state_r == IDLE) && start) begin
      err_s = 1'b0;
    end else if (fetch_done && (state_r != WAIT_DONE)) begin
      err_s = 1'b1;
    end else begin
      err_s = err_r;
    end
  end

  // State plus outputs decoded from the upcoming state, so each output is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r              <= IDLE;
      err_r                <= 1'b0;
      start_fetch_r        <= 1'b0;
      reset_addr_counter_r <= 1'b0;
      tile_valid_r         <= 1'b0;
      busy_r               <= 1'b0;
      pass_done_r          <= 1'b0;
    end else begin
      state_r              <= state_s;
      err_r                <= err_s;
      start_fetch_r        <= (state_s == ISSUE);
      reset_addr_counter_r <= (state_s == CLEAR);
      tile_valid_r         <= (state_s == WAIT_READY);
      busy_r               <= (state_s != IDLE);
      pass_done_r          <= (state_s == FINISH);
    end
  end

  assign start_fetch        = start_fetch_r;
  assign reset_addr_counter = reset_addr_counter_r;
  assign tile_valid         = tile_valid_r;
  assign busy               = busy_r;
  assign pass_done          = pass_done_r;
  assign err                = err_r;

endmodule

// File: doc/qkv_fetch_scheduler.md
# qkv_fetch_scheduler

Sequencer that drives `fetch_logic_gen` over a full Q/K/V projection pass: for each of `NUM_OFFSETS` offset groups it clears the address counter, then issues `NUM_TILES` tile fetches. Each fetch waits for `fetch_done` and then for the downstream systolic array to accept the tile before the next fetch starts. It sits between the layer-level controller and the Q/K/V buffer fetch path, and owns `start_fetch`, `reset_addr_counter` and `Offset_Control`.

## Interface
- `NUM_TILES`, 24, tile fetches per offset group (768 columns / 32).
- `NUM_OFFSETS`, 3, offset groups per pass (0 = Q, 1 = K, 2 = V); legal range 1..8.
- `TILE_W`, `$clog2(NUM_TILES)` (min 1), width of `tile_idx`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  pass request; sampled only in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE.
- `fetch_done`  in  1  tile-complete pulse from fetch logic.
- `sa_ready`  in  1  consumer accepts the current tile.
- `start_fetch`  out  1  one-cycle fetch launch.
- `reset_addr_counter`  out  1  one-cycle address clear.
- `Offset_Control`  out  3  current offset group.
- `tile_idx`  out  `TILE_W`  tile index within the group.
- `tile_valid`  out  1  tile fetched, awaiting `sa_ready`.
- `busy`  out  1  high in every state except IDLE.
- `pass_done`  out  1  one-cycle end-of-pass pulse.
- `err`  out  1  sticky protocol error.

## Operation
- All outputs are registered. After reset, every output is 0 and the state is IDLE.
- State machine:
  - IDLE: on `start` → CLEAR, with offset = 0, tile = 0 and `err` cleared.
  - CLEAR: `reset_addr_counter` = 1 for one cycle → ISSUE.
  - ISSUE: `start_fetch` = 1 for one cycle → WAIT_DONE.
  - WAIT_DONE: on `fetch_done` → WAIT_READY.
  - WAIT_READY: `tile_valid` = 1. On `sa_ready`:
    - last tile of last offset → FINISH;
    - last tile of the group → CLEAR, with offset+1 and tile = 0;
    - otherwise → ISSUE, with tile+1.
  - FINISH: `pass_done` = 1 for one cycle → IDLE.
- `Offset_Control` and `tile_idx` are updated on the transition out of WAIT_READY. They hold stable from CLEAR/ISSUE until the next WAIT_READY exit.
- `fetch_done` outside WAIT_DONE is ignored for sequencing and sets `err`.
- `sa_ready` outside WAIT_READY is ignored.
- `start` while busy is ignored and does not set `err`.
- `abort` in any state → IDLE on the next edge.
  - Counters, `Offset_Control` and `tile_idx` reset to 0.
  - `err` is held.
  - No `pass_done` is issued.
  - `abort` has priority over every other input.
- Reset mid-pass behaves like `abort`, and additionally clears `err`.
- Counters are compared against `NUM_TILES-1` and `NUM_OFFSETS-1`; they never wrap past those limits.

## Timing
- `start` sampled at edge 0:
  - CLEAR during cycle 1 (`reset_addr_counter` high);
  - ISSUE during cycle 2 (`start_fetch` high);
  - WAIT_DONE from cycle 3.
- `fetch_done` sampled at edge N → `tile_valid` high in cycle N+1.
- `sa_ready` high during the first WAIT_READY cycle → ISSUE in the next cycle.
- Minimum cycles per tile:
  - within a group: 3 (ISSUE, WAIT_DONE, WAIT_READY);
  - at a group boundary: 4 (adds CLEAR).
- `pass_done` is asserted in the cycle after the final `sa_ready`. `busy` drops in the following cycle.
- `fetch_done` in the same cycle as entering WAIT_DONE is not possible. Fetch logic latency is ≥1 cycle after `start_fetch`.

## Structure
- Package `qkv_sched_pkg` holds:
  - the state enum (IDLE, CLEAR, ISSUE, WAIT_DONE, WAIT_READY, FINISH);
  - offset constants `OFF_Q = 0`, `OFF_K = 1`, `OFF_V = 2`;
  - default `NUM_TILES` / `NUM_OFFSETS`.
- One sub-module, `qkv_tile_counter`: the nested tile/offset counter with `last_tile` / `last_offset` flags. The FSM stays in the top module.

## Test plan
- Full pass, with `NUM_TILES` = 2, `NUM_OFFSETS` = 3, `fetch_done` 4 cycles after each `start_fetch`, and `sa_ready` tied high:
  - 6 `start_fetch` pulses and 3 `reset_addr_counter` pulses;
  - `Offset_Control` sequence 0,0,1,1,2,2;
  - one `pass_done`; `err` = 0.
- Backpressure: hold `sa_ready` low for 10 cycles on tile 1 → `tile_valid` held for 10 cycles; no `start_fetch` during the stall; resumes one cycle after `sa_ready`.
- Abort during WAIT_DONE of offset 1, tile 0 → IDLE next cycle; all outputs 0; no `pass_done`. A following `start` begins again at offset 0.
- Spurious `fetch_done` during WAIT_READY → `err` = 1 and the sequence is unaffected. `err` clears on the next accepted `start`.
- `start` pulsed while busy → ignored; exactly one `pass_done`.
- `rst_n` low for one cycle mid-pass → all outputs 0 on the next edge, including `err`.
